// File: rtl/irq_pkg.sv
// irq_pkg
// Shared constants for the interrupt controller: interrupt bit positions,
// default register addresses (low address byte inside the 0xFFxx window)
// and the mask of IF bits that have no interrupt source behind them.
package irq_pkg;

  // Interrupt bit positions, in SM83 priority order (bit 0 is highest).
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam int IRQ_COUNT = 5;

  // Low address byte of each register when MMIO_REQ is high.
  localparam logic [7:0] IF_ADDR_DEFAULT = 8'h0F;
  localparam logic [7:0] IE_ADDR_DEFAULT = 8'hFF;

  // IF bits above the implemented sources always read back as 1.
  localparam logic [7:0] IF_UNUSED_MASK = 8'hE0;

endpackage

// File: rtl/irq_edge.sv
// irq_edge
// Registered rising-edge detector. It keeps the previous sample of d and
// flags every bit that is high now but was low on the previous edge.
// Ports:
//   clk     - clock, state updates on the rising edge
//   n_reset - synchronous active-low reset (clears the previous sample)
//   d       - WIDTH-bit level input
//   rise    - d & ~previous d, combinational from d and the register
module irq_edge #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] d_q;

  // Clearing the history on reset means an input already high at release
  // is reported as a rise on the first active edge.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      d_q <= '0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Memory-mapped interrupt controller in front of the SM83 core. Holds the
// IF and IE registers, latches rising edges of the peripheral request
// lines into IF and presents the enabled, pending requests to the core.
// Ports:
//   CLK, nRESET        - clock and synchronous active-low reset
//   A, MMIO_REQ        - CPU address (low byte decoded) and 0xFExx/0xFFxx qualifier
//   RD, WR, D_in       - read strobe, level write strobe, write data
//   D_out, D_oe        - read data (00 when not driving) and its drive enable
//   PERIPH_REQ         - raw requests: VBlank, STAT, Timer, Serial, Joypad
//   CPU_IRQ_ACK        - one-hot acknowledge from the core
//   CPU_IRQ_TRIG       - pending & enabled requests to the core
//   IRQ_PENDING        - OR of CPU_IRQ_TRIG, HALT wake source
module irq_controller
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ = IRQ_COUNT,
  parameter logic [7:0] IF_ADDR = IF_ADDR_DEFAULT,
  parameter logic [7:0] IE_ADDR = IE_ADDR_DEFAULT
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [15:0]        A,
  input  logic               MMIO_REQ,
  input  logic               RD,
  input  logic               WR,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic [NUM_IRQ-1:0] PERIPH_REQ,
  input  logic [7:0]         CPU_IRQ_ACK,
  output logic [7:0]         CPU_IRQ_TRIG,
  output logic               IRQ_PENDING
);

  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] rise;
  logic               wcommit;
  logic               sel_if;
  logic               sel_ie;
  logic [NUM_IRQ-1:0] if_base;
  logic [NUM_IRQ-1:0] if_next;
  logic [7:0]         if_read;
  logic               unused_bits;

  // Upper address byte is pre-decoded into MMIO_REQ; ack bits without a
  // source are deliberately ignored.
  assign unused_bits = ^{A[15:8], CPU_IRQ_ACK};

  assign sel_if = MMIO_REQ && (A[7:0] == IF_ADDR);
  assign sel_ie = MMIO_REQ && (A[7:0] == IE_ADDR);

  irq_edge #(
    .WIDTH(NUM_IRQ)
  ) u_req_edge (
    .clk    (CLK),
    .n_reset(nRESET),
    .d      (PERIPH_REQ),
    .rise   (rise)
  );

  // WR is a level that may stay high for several cycles; only its first
  // edge commits, so a long write cannot wipe out rises that arrive later.
  irq_edge #(
    .WIDTH(1)
  ) u_wr_edge (
    .clk    (CLK),
    .n_reset(nRESET),
    .d      (WR),
    .rise   (wcommit)
  );

  // IF next state: CPU write first, then acknowledges clear, then new
  // edges set. A fresh edge therefore survives a same-cycle ack or write.
  always_comb begin
    if_base = if_q;
    if (wcommit && sel_if) begin
      if_base = D_in[NUM_IRQ-1:0];
    end
    if_next = (if_base & ~CPU_IRQ_ACK[NUM_IRQ-1:0]) | rise;
  end

  // Register state; reset wins over every simultaneous event.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      if_q <= '0;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_next;
      if (wcommit && sel_ie) begin
        ie_q <= D_in;
      end
    end
  end

  // Unimplemented IF bits are hardwired high on readback.
  always_comb begin
    if_read = 8'hFF;
    if_read[NUM_IRQ-1:0] = if_q;
  end

  // Zero-latency read mux; the bus sees 00 whenever we are not driving.
  always_comb begin
    D_oe  = RD && (sel_if || sel_ie);
    D_out = 8'h00;
    if (RD && sel_if) begin
      D_out = if_read;
    end else if (RD && sel_ie) begin
      D_out = ie_q;
    end
  end

  // Core-facing request vector comes purely from registers.
  always_comb begin
    CPU_IRQ_TRIG = 8'h00;
    CPU_IRQ_TRIG[NUM_IRQ-1:0] = if_q & ie_q[NUM_IRQ-1:0];
  end

  assign IRQ_PENDING = |CPU_IRQ_TRIG;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Table-driven bench for irq_controller. Each record gives the inputs held
// for one clock cycle and the outputs expected just before the edge that
// consumes them (state from earlier records plus the current inputs).
module tb_irq_controller;

  logic        clk;
  logic        n_reset;
  logic [15:0] a;
  logic        mmio_req;
  logic        rd;
  logic        wr;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [4:0]  periph_req;
  logic [7:0]  cpu_irq_ack;
  logic [7:0]  cpu_irq_trig;
  logic        irq_pending;

  int checks;
  int errors;

  typedef struct {
    bit         rst_n;
    logic [7:0] addr;
    bit         mmio;
    bit         rd;
    bit         wr;
    logic [7:0] din;
    logic [4:0] periph;
    logic [7:0] ack;
    logic [7:0] exp_dout;
    bit         exp_oe;
    logic [7:0] exp_trig;
  } vec_t;

  vec_t vecs[$];

  irq_controller dut (
    .CLK         (clk),
    .nRESET      (n_reset),
    .A           (a),
    .MMIO_REQ    (mmio_req),
    .RD          (rd),
    .WR          (wr),
    .D_in        (d_in),
    .D_out       (d_out),
    .D_oe        (d_oe),
    .PERIPH_REQ  (periph_req),
    .CPU_IRQ_ACK (cpu_irq_ack),
    .CPU_IRQ_TRIG(cpu_irq_trig),
    .IRQ_PENDING (irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(bit rst_n, logic [7:0] addr, bit mmio, bit rdv, bit wrv,
                              logic [7:0] din, logic [4:0] periph, logic [7:0] ack,
                              logic [7:0] exp_dout, bit exp_oe, logic [7:0] exp_trig);
    vec_t v;
    v.rst_n = rst_n;  v.addr = addr;  v.mmio = mmio;  v.rd = rdv;  v.wr = wrv;
    v.din = din;  v.periph = periph;  v.ack = ack;
    v.exp_dout = exp_dout;  v.exp_oe = exp_oe;  v.exp_trig = exp_trig;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    n_reset     = v.rst_n;
    a           = {8'hFF, v.addr};
    mmio_req    = v.mmio;
    rd          = v.rd;
    wr          = v.wr;
    d_in        = v.din;
    periph_req  = v.periph;
    cpu_irq_ack = v.ack;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic exp_pend;
    exp_pend = (v.exp_trig != 8'h00);
    checks++;
    if (d_out !== v.exp_dout) begin
      errors++;
      $display("[TB] FAIL %s d_out: got %02h expected %02h", tag, d_out, v.exp_dout);
    end
    checks++;
    if (d_oe !== v.exp_oe) begin
      errors++;
      $display("[TB] FAIL %s d_oe: got %0b expected %0b", tag, d_oe, v.exp_oe);
    end
    checks++;
    if (cpu_irq_trig !== v.exp_trig) begin
      errors++;
      $display("[TB] FAIL %s trig: got %02h expected %02h", tag, cpu_irq_trig, v.exp_trig);
    end
    checks++;
    if (irq_pending !== exp_pend) begin
      errors++;
      $display("[TB] FAIL %s pending: got %0b expected %0b", tag, irq_pending, exp_pend);
    end
  endtask

  // One cycle: drive after the falling edge, sample shortly after, then
  // let the next rising edge consume the inputs.
  task automatic runVector(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput(v, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            rst addr  mm rd wr din    periph  ack    dout   oe trig
    // Reset state readback, IE write, single-cycle Timer pulse, ack.
    vecs.push_back(mk(0, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE0, 1, 8'h00)); // 0
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'h00, 1, 8'h00)); // 1
    vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 8'h05, 5'h00, 8'h00, 8'h00, 0, 8'h00)); // 2 IE=05
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 5'h04, 8'h00, 8'h00, 0, 8'h00)); // 3 pulse timer
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE4, 1, 8'h04)); // 4
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 8'h00, 5'h00, 8'h04, 8'h05, 1, 8'h04)); // 5 ack timer
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE0, 1, 8'h00)); // 6
    // Level-held VBlank: ack clears it and it stays clear until re-raised.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h00, 8'hE0, 1, 8'h00)); // 7
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h01, 8'hE1, 1, 8'h01)); // 8
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h00, 8'hE0, 1, 8'h00)); // 9
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE0, 1, 8'h00)); // 10
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h00, 8'hE0, 1, 8'h00)); // 11 re-raise
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE1, 1, 8'h01)); // 12
    // Same edge: ack bit 0 together with a new rise on bit 0.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h01, 8'hE1, 1, 8'h01)); // 13
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h01, 8'h00, 8'hE1, 1, 8'h01)); // 14
    // Same edge: write IF=00 together with a Serial rise.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'h00, 5'h09, 8'h00, 8'hE1, 1, 8'h01)); // 15
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h09, 8'h00, 8'hE8, 1, 8'h00)); // 16
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h08, 8'hE8, 1, 8'h00)); // 17
    // WR held four cycles with D_in=1F; ack clears, STAT rises mid-hold.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'h1F, 5'h00, 8'h00, 8'hE0, 1, 8'h00)); // 18 commit
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'h1F, 5'h00, 8'h1F, 8'hFF, 1, 8'h05)); // 19
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'h1F, 5'h02, 8'h00, 8'hE0, 1, 8'h00)); // 20
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'h1F, 5'h02, 8'h00, 8'hE2, 1, 8'h00)); // 21
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hE2, 1, 8'h00)); // 22
    // Load IE=FF and IF=FF, then reset with a write and rises pending.
    vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 8'hFF, 5'h00, 8'h00, 8'h00, 0, 8'h00)); // 23
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hFF, 1, 8'h02)); // 24
    vecs.push_back(mk(1, 8'h0F, 1, 1, 1, 8'hFF, 5'h00, 8'h00, 8'hE2, 1, 8'h02)); // 25
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h00, 8'h00, 8'hFF, 1, 8'h1F)); // 26
    vecs.push_back(mk(0, 8'h0F, 1, 1, 1, 8'h00, 5'h1F, 8'h00, 8'hFF, 1, 8'h1F)); // 27 reset
    // Requests high across release are seen as rises at the first edge.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h1F, 8'h00, 8'hE0, 1, 8'h00)); // 28
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 8'h00, 5'h1F, 8'h00, 8'h00, 1, 8'h00)); // 29
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h1F, 8'h00, 8'hFF, 1, 8'h00)); // 30
    // WR already high at release commits on the first active edge.
    vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 8'h03, 5'h1F, 8'h00, 8'h00, 0, 8'h00)); // 31
    vecs.push_back(mk(1, 8'hFF, 1, 1, 1, 8'h03, 5'h1F, 8'h00, 8'h00, 1, 8'h00)); // 32
    vecs.push_back(mk(1, 8'hFF, 1, 1, 1, 8'h03, 5'h1F, 8'h00, 8'h03, 1, 8'h03)); // 33
    // Not selected: MMIO_REQ low, then an unmapped low byte.
    vecs.push_back(mk(1, 8'h0F, 0, 1, 0, 8'h00, 5'h1F, 8'h00, 8'h00, 0, 8'h03)); // 34
    vecs.push_back(mk(1, 8'h10, 1, 1, 0, 8'h00, 5'h1F, 8'h00, 8'h00, 0, 8'h03)); // 35
    // Multi-bit ack including ignored upper bits.
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h1F, 8'hE3, 8'hFF, 1, 8'h03)); // 36
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h1F, 8'h00, 8'hFC, 1, 8'h00)); // 37

    // Park inputs and hold reset for two edges before the table starts.
    applyStimulus(mk(0, 8'h00, 0, 0, 0, 8'h00, 5'h00, 8'h00, 8'h00, 0, 8'h00));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: Joypad wake latency. Clear everything, enable only
    // Joypad, then check IRQ_PENDING is low before and high after the
    // edge that samples the rise.
    runVector(mk(1, 8'h00, 0, 0, 0, 8'h00, 5'h00, 8'h1F, 8'h00, 0, 8'h00), "wake_clear");
    runVector(mk(1, 8'hFF, 1, 0, 1, 8'h10, 5'h00, 8'h00, 8'h00, 0, 8'h00), "wake_ie");
    runVector(mk(1, 8'h00, 0, 0, 0, 8'h00, 5'h10, 8'h00, 8'h00, 0, 8'h00), "wake_rise");
    runVector(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h10, 8'h00, 8'hF0, 1, 8'h10), "wake_seen");
    runVector(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h10, 8'h10, 8'hF0, 1, 8'h10), "wake_ack");
    runVector(mk(1, 8'h0F, 1, 1, 0, 8'h00, 5'h10, 8'h00, 8'hE0, 1, 8'h00), "wake_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller sitting directly upstream of the SM83 core. It holds the IF (0xFF0F) and IE (0xFFFF) registers and latches rising edges from the five peripheral request lines. It drives `CPU_IRQ_TRIG` into the core and clears pending bits on the core's one-hot `CPU_IRQ_ACK`. Register reads and writes arrive over the CPU address/data bus, qualified by `MMIO_REQ`.

## Interface
Parameters:
- `NUM_IRQ`, 5: implemented interrupt sources; bits above `NUM_IRQ-1` are hardwired.
- `IF_ADDR`, 8'h0F: low address byte of IF when `MMIO_REQ`=1.
- `IE_ADDR`, 8'hFF: low address byte of IE when `MMIO_REQ`=1.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `nRESET`  in  1  reset, synchronous, active-low.
- `A`  in  16  CPU address bus; only `A[7:0]` is decoded.
- `MMIO_REQ`  in  1  high when the address is 0xFExx or 0xFFxx.
- `RD`  in  1  CPU read strobe.
- `WR`  in  1  CPU write strobe; level signal, may last several cycles.
- `D_in`  in  8  CPU write data.
- `D_out`  out  8  read data; 8'h00 when not selected.
- `D_oe`  out  1  drive enable for `D_out`.
- `PERIPH_REQ`  in  5  raw requests, [0]=VBlank, [1]=STAT, [2]=Timer, [3]=Serial, [4]=Joypad.
- `CPU_IRQ_ACK`  in  8  core acknowledge, one-hot.
- `CPU_IRQ_TRIG`  out  8  pending and enabled requests, to the core.
- `IRQ_PENDING`  out  1  OR of `CPU_IRQ_TRIG`; used as the HALT wake source.

## Operation
- State: `if_q[4:0]`, `ie_q[7:0]`, `req_q[4:0]` (previous `PERIPH_REQ`), `wr_q` (previous `WR`).
- Register select:
  - `sel_if` = `MMIO_REQ` & `A[7:0]`==`IF_ADDR`.
  - `sel_ie` = `MMIO_REQ` & `A[7:0]`==`IE_ADDR`.
- Write commit: `wcommit` = `WR` & ~`wr_q`. Exactly one commit per `WR` pulse.
- Rise detect: `rise[i]` = `PERIPH_REQ[i]` & ~`req_q[i]`. Level-high requests do not re-set IF.
- `if_q` next-state, in priority order:
  1. base = (`wcommit` & `sel_if`) ? `D_in[4:0]` : `if_q`.
  2. Clear every bit where `CPU_IRQ_ACK[i]`=1.
  3. OR in `rise`. A new edge therefore beats both an ack and a CPU write in the same cycle.
- `ie_q`: loaded with `D_in[7:0]` on `wcommit` & `sel_ie`. All 8 bits are read/write storage; only [4:0] gate interrupts.
- Read data, combinational:
  - `D_oe` = `RD` & (`sel_if` | `sel_ie`).
  - IF reads {3'b111, `if_q`}.
  - IE reads `ie_q`.
- `CPU_IRQ_TRIG` = {3'b000, `if_q` & `ie_q[4:0]`}. Combinational from registers; no input-to-output combinational path.
- `CPU_IRQ_ACK[7:5]` are ignored. Multiple ack bits in one cycle clear all of them; no error is raised.

## Timing
- Reset (`nRESET`=0 at an edge):
  - `if_q`=0 and `ie_q`=0, so IF reads 8'hE0 and IE reads 8'h00.
  - `req_q`=0 and `wr_q`=0.
  - `CPU_IRQ_TRIG`=0 and `IRQ_PENDING`=0 on the cycle after the edge.
  - Reset overrides every simultaneous write, ack or rise.
- Reset release:
  - A `PERIPH_REQ` already high at release is seen as a rise on the first active edge.
  - A `WR` already high at release commits on the first active edge.
- Latency:
  - `PERIPH_REQ` rise sampled at edge n: `if_q` set after edge n; `CPU_IRQ_TRIG` high during cycle n+1 if enabled.
  - Ack sampled at edge n: `CPU_IRQ_TRIG` bit low in cycle n+1.
  - Write commit at edge n: new value visible to reads and `CPU_IRQ_TRIG` in cycle n+1.
- Read has zero-cycle latency from `A`/`RD`/`MMIO_REQ`.
- A request pulse shorter than one `CLK` period may be missed. Peripherals must hold it for at least one edge.
- A write held for many cycles commits only at its first edge. Rises during the hold are kept.

## Structure
- Package `irq_pkg`:
  - bit indices `IRQ_VBLANK`..`IRQ_JOYPAD`;
  - `IF_ADDR`/`IE_ADDR` defaults;
  - `IF_UNUSED_MASK` = 8'hE0.
- One sub-module, `irq_edge`: `NUM_IRQ`-wide registered rise detector with synchronous active-low reset, outputs `rise`. Instantiated once for `PERIPH_REQ`.
- The `WR` edge detect is a 1-bit instance of the same `irq_edge`.

## Test plan
- Reset then read 0xFF0F and 0xFFFF -> `D_out`=8'hE0 then 8'h00, `D_oe`=1; `CPU_IRQ_TRIG`=0.
- Write IE=8'h05, pulse `PERIPH_REQ[2]` for 1 cycle -> IF reads 8'hE4, `CPU_IRQ_TRIG`=8'h04 next cycle, `IRQ_PENDING`=1; `CPU_IRQ_ACK`=8'h04 -> `CPU_IRQ_TRIG`=0 one cycle later.
- Hold `PERIPH_REQ[0]` high, ack bit 0 -> IF bit 0 stays clear while the request stays high; drop and re-raise -> bit 0 set again.
- Same edge: `CPU_IRQ_ACK`=8'h01 and rise on `PERIPH_REQ[0]` -> IF[0]=1 afterwards. Same edge: write IF=8'h00 and rise on `PERIPH_REQ[3]` -> IF reads 8'hE8.
- `WR` held 4 cycles to IF with `D_in`=8'h1F; `PERIPH_REQ[1]` rises in cycle 2 after IF was cleared by ack -> single commit, IF[1]=1 remains.
- `nRESET` low for one edge with IF=8'hFF and IE=8'hFF -> IF reads 8'hE0, IE 8'h00, `CPU_IRQ_TRIG`=0 next cycle.
